regfile_mb2w: RTL and testbench
===============================

Name: regfile_mb2w

Overview:
- Parametrised successor to the CPU general-purpose register file.
- Generalised data width and depth; two write ports (for the W stage and a late-result/MDU writeback path) with a defined collision rule.
- Write-to-read bypass, so the decode stage needs no separate W→D forward mux.
- Optional shadow register bank for exception entry/return, plus a multi-cycle hardware clear sequencer.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- NBANK, 2, number of banks (1 or 2); with 1, bank_swap is ignored and active_bank stays 0
- RIDX_A, 28, index of first preset register
- RVAL_A, 32'h0000_1800, reset/clear value of entry RIDX_A
- RIDX_B, 29, index of second preset register
- RVAL_B, 32'h0000_2ffc, reset/clear value of entry RIDX_B

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- we0  in  1  write enable, port 0 (W-stage writeback)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (late-result writeback)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- bank_swap  in  1  one-cycle pulse: toggle active bank
- clr_start  in  1  one-cycle pulse: start clear of active bank
- busy  out  1  clear sequence in progress
- active_bank  out  1  currently selected bank

Behaviour:
- Reset (clk edge with rst=1) has priority over every other input.
  - Every entry of every bank = 0, except RIDX_A = RVAL_A and RIDX_B = RVAL_B.
  - active_bank = 0, FSM = IDLE, busy = 0, clear counter = 0.
  - rst asserted mid-clear aborts the clear and performs a full reset.
- Entry 0: always reads 0. Writes to address 0 are discarded on both ports and are never bypassed.
- Writes: on a clk edge with weN=1, waN≠0 and FSM=IDLE, entry waN of the active bank ← wdN.
- Write collision: if we0 and we1 are both set and wa0 == wa1, port 1 wins and wd0 is dropped.
- Read data: rdK = stored[active_bank][raK], overridden by bypass in this priority order:
  - raK == 0 → 0
  - we1 && wa1 == raK && IDLE → wd1
  - we0 && wa0 == raK && IDLE → wd0
  - otherwise → stored value
  - A same-cycle write is therefore visible combinationally. Zero-latency bypass; write latency to storage is 1 edge.
- Bank swap: bank_swap=1 on an edge in IDLE toggles active_bank.
  - Writes in that same cycle go to the old bank.
  - Reads after the edge see the new bank.
  - bank_swap while busy=1 is ignored; it is not queued.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on an edge with clr_start=1; clear counter ← 1.
  - While in CLEAR:
    - busy=1.
    - Each edge writes the active bank entry [counter] with its reset value (RVAL_A/RVAL_B at the preset indices, else 0), then counter increments.
    - we0/we1 are ignored and bypass is disabled.
    - Reads return stored contents, so entries already cleared read their reset value.
  - CLEAR → IDLE on the edge that writes entry 2**ADDR_W−1; busy drops after that edge.
  - A full clear takes 2**ADDR_W−1 cycles (31 at default).
  - clr_start while busy is ignored.
  - clr_start and bank_swap on the same IDLE edge: the swap takes effect first, so the newly active bank is cleared.
  - Writes on the clr_start edge still commit, but are overwritten as the sweep reaches them.
- The inactive bank is never modified except by rst.

Test Plan:
- Reset then read: rst 1 cycle; read ra1=28, ra2=29 → rd1=0x00001800, rd2=0x00002ffc; ra1=5 → 0; busy=0, active_bank=0.
- Bypass: we0=1, wa0=7, wd0=0xDEADBEEF, ra1=7 in the same cycle → rd1=0xDEADBEEF before the edge; after the edge with we0=0 → still 0xDEADBEEF.
- Collision and zero register: wa0=wa1=9, wd0=0x11, wd1=0x22 → rd(9)=0x22 both during the cycle and afterwards; we0=1, wa0=0, wd0=0xFF → rd(0)=0.
- Bank swap: write $3=0xA in bank 0; pulse bank_swap → active_bank=1, rd(3)=0; write $3=0xB; swap back → rd(3)=0xA.
- Clear sequence: fill $1..$31 with 0x55; pulse clr_start; busy=1 for exactly 31 cycles; we0 to $4 during CLEAR has no effect; after completion rd(4)=0, rd(28)=0x1800, rd(29)=0x2ffc; the inactive bank is unchanged.
- Reset mid-clear: assert rst at clear cycle 10 → busy=0 on the next cycle, active_bank=0, all entries at reset values; clr_start accepted afterwards.

Source files
------------

// File: rtl/regfile_mb2w.sv
// Two-write, two-read register file with optional shadow bank and hardware clear sweep.
// Reads are combinational with same-cycle write bypass. Writes land 1 edge later. No backpressure: busy only gates writes during a clear.
module regfile_mb2w #(
    parameter int                 DATA_W = 32,
    parameter int                 ADDR_W = 5,
    parameter int                 NBANK  = 2,
    parameter int                 RIDX_A = 28,
    parameter logic [DATA_W-1:0]  RVAL_A = DATA_W'(32'h0000_1800),
    parameter int                 RIDX_B = 29,
    parameter logic [DATA_W-1:0]  RVAL_B = DATA_W'(32'h0000_2ffc)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              bank_swap,
    input  logic              clr_start,
    output logic              busy,
    output logic              active_bank
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              bank_q, bank_d;
    // Two banks are always declared; with NBANK=1 bank 1 is never selected.
    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [DATA_W-1:0] mem_d [2][DEPTH];
    logic              idle;

    function automatic logic [DATA_W-1:0] reset_val(input logic [ADDR_W-1:0] idx);
        if (idx == ADDR_W'(RIDX_A)) return RVAL_A;
        if (idx == ADDR_W'(RIDX_B)) return RVAL_B;
        return '0;
    endfunction

    assign idle        = (state_q == IDLE);
    assign busy        = (state_q == CLEAR);
    assign active_bank = bank_q;

    // Port 1 is checked first so it wins a same-address collision on the bypass path too.
    assign rd1 = (ra1 == '0)                   ? '0  :
                 (idle && we1 && wa1 == ra1)   ? wd1 :
                 (idle && we0 && wa0 == ra1)   ? wd0 :
                                                 mem_q[bank_q][ra1];
    assign rd2 = (ra2 == '0)                   ? '0  :
                 (idle && we1 && wa1 == ra2)   ? wd1 :
                 (idle && we0 && wa0 == ra2)   ? wd0 :
                                                 mem_q[bank_q][ra2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        mem_d   = mem_q;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
            bank_d  = 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_d[1'(b)][ADDR_W'(i)] = reset_val(ADDR_W'(i));
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Writes use the bank selected before any swap on this edge.
                    if (we0 && wa0 != '0) mem_d[bank_q][wa0] = wd0;
                    if (we1 && wa1 != '0) mem_d[bank_q][wa1] = wd1;
                    if (bank_swap && NBANK == 2) bank_d = ~bank_q;
                    if (clr_start) begin
                        state_d = CLEAR;
                        cnt_d   = ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    mem_d[bank_q][cnt_q] = reset_val(cnt_q);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bank_q  <= bank_d;
        mem_q   <= mem_d;
    end

endmodule

// File: tb/tb_regfile_mb2w.sv
// Randomized and directed bench for regfile_mb2w against an array-based reference model.
module tb_regfile_mb2w;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa0, wa1;
    logic [31:0] rd1, rd2, wd0, wd1;
    logic        we0, we1, bank_swap, clr_start, busy, active_bank;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [2][32];
    bit          ref_bank;
    bit          ref_clr;
    int          ref_idx;

    regfile_mb2w dut (
        .clk(clk), .rst(rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .bank_swap(bank_swap), .clr_start(clr_start),
        .busy(busy), .active_bank(active_bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rv(input int i);
        if (i == 28) return 32'h0000_1800;
        if (i == 29) return 32'h0000_2ffc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (!ref_clr) begin
            if (we1 && wa1 == ra) return wd1;
            if (we0 && wa0 == ra) return wd0;
        end
        return ref_mem[ref_bank][ra];
    endfunction

    task automatic model_step();
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 32; i++) ref_mem[b][i] = rv(i);
            ref_bank = 1'b0;
            ref_clr  = 1'b0;
            ref_idx  = 0;
        end else if (ref_clr) begin
            ref_mem[ref_bank][ref_idx] = rv(ref_idx);
            ref_idx++;
            if (ref_idx == 32) ref_clr = 1'b0;
        end else begin
            if (we0 && wa0 != 5'd0) ref_mem[ref_bank][wa0] = wd0;
            if (we1 && wa1 != 5'd0) ref_mem[ref_bank][wa1] = wd1;
            if (bank_swap) ref_bank = !ref_bank;
            if (clr_start) begin
                ref_clr = 1'b1;
                ref_idx = 1;
            end
        end
    endtask

    // Entered one time unit after a rising edge; checks outputs late in the cycle, then advances.
    task automatic tick(input bit do_chk = 1'b1);
        #2;
        if (do_chk) begin
            check("rd1", rd1, exp_rd(ra1));
            check("rd2", rd2, exp_rd(ra2));
            check("busy", {31'b0, busy}, {31'b0, ref_clr});
            check("active_bank", {31'b0, active_bank}, {31'b0, ref_bank});
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; bank_swap = 1'b0; clr_start = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra1 = '0; ra2 = '0;
    endtask

    initial begin
        int n;
        idle_in();
        rst = 1'b1;
        #1;
        tick(1'b0);
        rst = 1'b0;

        // Reset values
        ra1 = 5'd28; ra2 = 5'd29;
        #1;
        check("rst_r28", rd1, 32'h0000_1800);
        check("rst_r29", rd2, 32'h0000_2ffc);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_bank", {31'b0, active_bank}, 32'h0);
        tick();
        ra1 = 5'd5;
        #1;
        check("rst_r5", rd1, 32'h0);
        tick();

        // Bypass
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEAD_BEEF; ra1 = 5'd7;
        #1;
        check("byp_same", rd1, 32'hDEAD_BEEF);
        tick();
        we0 = 1'b0;
        #1;
        check("byp_after", rd1, 32'hDEAD_BEEF);
        tick();

        // Collision and zero register
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd9; wa1 = 5'd9; wd0 = 32'h11; wd1 = 32'h22;
        ra1 = 5'd9; ra2 = 5'd9;
        #1;
        check("coll_same", rd1, 32'h22);
        tick();
        idle_in(); ra1 = 5'd9;
        #1;
        check("coll_after", rd1, 32'h22);
        tick();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFF; ra1 = 5'd0;
        #1;
        check("zero_same", rd1, 32'h0);
        tick();
        idle_in();
        #1;
        check("zero_after", rd1, 32'h0);
        tick();

        // Bank swap
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA;
        tick();
        idle_in(); bank_swap = 1'b1;
        tick();
        idle_in(); ra1 = 5'd3;
        #1;
        check("swap_bank", {31'b0, active_bank}, 32'h1);
        check("swap_rd_new", rd1, 32'h0);
        tick();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hB;
        tick();
        idle_in(); bank_swap = 1'b1;
        tick();
        idle_in(); ra1 = 5'd3;
        #1;
        check("swap_back", rd1, 32'hA);
        tick();

        // Clear sweep over bank 0
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; wa0 = 5'(i); wd0 = 32'h55; ra1 = 5'(i);
            tick();
        end
        idle_in(); clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h99; ra1 = 5'd4; ra2 = 5'($urandom);
            tick();
            n++;
        end
        check("clr_cycles", n, 32'd31);
        idle_in(); ra1 = 5'd4; ra2 = 5'd28;
        #1;
        check("clr_r4", rd1, 32'h0);
        check("clr_r28", rd2, 32'h0000_1800);
        tick();
        ra1 = 5'd29; ra2 = 5'd31;
        #1;
        check("clr_r29", rd1, 32'h0000_2ffc);
        check("clr_r31", rd2, 32'h0);
        tick();
        idle_in(); bank_swap = 1'b1;
        tick();
        idle_in(); ra1 = 5'd3;
        #1;
        check("inactive_kept", rd1, 32'hB);
        tick();

        // Reset in the middle of a clear (active bank is 1 here)
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; ra1 = 5'd28; ra2 = 5'd3;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_bank", {31'b0, active_bank}, 32'h0);
        check("mid_rst_r28", rd1, 32'h0000_1800);
        check("mid_rst_r3", rd2, 32'h0);
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        #1;
        check("clr_again", {31'b0, busy}, 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("clr_again_cycles", n, 32'd31);

        // Random traffic
        repeat (600) begin
            rst       = ($urandom_range(0, 149) == 0);
            we0       = 1'($urandom);
            we1       = 1'($urandom);
            wa0       = 5'($urandom);
            wa1       = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
            wd0       = $urandom;
            wd1       = $urandom;
            ra1       = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
            ra2       = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom);
            bank_swap = ($urandom_range(0, 11) == 0);
            clr_start = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
